// File: rtl/mips_mc_pkg.sv
// Shared constants and encodings for the multicycle MIPS control unit:
// opcodes, functs, FSM states, ALUOp and ALUControl codes.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: ALUOp plus funct field to ALUControl.
// Unknown functs and the reserved ALUOp fall back to add.
module alu_decoder
    import mips_mc_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS core; sequences the shared ALU,
// unified memory and register file. Outputs decode from the registered state.
module multicycle_control
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t st;
    state_t view;
    aluop_t alu_op;
    logic   pc_write, branch, ir_write, reg_write, mem_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_FETCH;
        end else begin
            case (st)
                S_FETCH:  st <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: st <= S_MEMADR;
                        OP_RTYPE:     st <= S_EXECUTE;
                        OP_BEQ:       st <= S_BRANCH;
                        OP_ADDI:      st <= S_ADDIEX;
                        OP_J:         st <= S_JUMP;
                        default:      st <= S_FETCH;
                    endcase
                end
                S_MEMADR:  st <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   st <= S_MEMWB;
                S_EXECUTE: st <= S_ALUWB;
                S_ADDIEX:  st <= S_ADDIWB;
                default:   st <= S_FETCH;
            endcase
        end
    end

    // During reset the datapath sees FETCH selects with every write enable held low.
    assign view = reset ? S_FETCH : st;

    always_comb begin
        IorD      = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        reg_write = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        PCSrc     = 2'b00;
        pc_write  = 1'b0;
        branch    = 1'b0;
        case (view)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign IRWrite    = ir_write & ~reset;
    assign RegWrite   = reg_write & ~reset;
    assign MemWrite   = mem_write & ~reset;
    assign PCEn       = ~reset & (pc_write | (branch & zero));
    assign illegal_op = ~reset & (st == S_DECODE) & ~is_legal(opcode);
    assign state      = st;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: directed instruction sequences then randomized ones,
// compared per cycle against a per-instruction state-sequence reference.
module tb_multicycle_control;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset, zero;
    logic [5:0] opcode, funct;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       PCEn, illegal_op;
    logic [3:0] state;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
        logic [1:0] pcsrc;
        logic       pcen, illegal;
    } ctl_t;

    ctl_t obs;
    assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op};

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    function automatic int len_of(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected control word for one cycle, read off the per-state output table.
    function automatic ctl_t exp_ctl(input int st, input bit rst, input logic [5:0] op,
                                     input logic [5:0] fn, input logic z);
        ctl_t e = '0;
        e.aluctl = 3'b010;
        if (rst) begin
            e.alusrcb = 2'b01;
            return e;
        end
        case (st)
            0:  begin e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1; end
            1:  begin e.alusrcb = 2'b11; e.illegal = !legal(op); end
            2, 9: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            3:  e.iord = 1;
            4:  begin e.memtoreg = 1; e.regwrite = 1; end
            5:  begin e.iord = 1; e.memwrite = 1; end
            6:  begin e.alusrca = 1; e.aluctl = alu_of(fn); end
            7:  begin e.regdst = 1; e.regwrite = 1; end
            8:  begin e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            10: e.regwrite = 1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input int exp_st, input bit rst,
                         input logic [5:0] op, input logic [5:0] fn, input logic z);
        ctl_t e;
        e = exp_ctl(exp_st, rst, op, fn, z);
        compared++;
        assert (state === 4'(exp_st)) else begin
            mismatched++;
            $error("FAIL %s state: got %0d want %0d", tag, state, exp_st);
        end
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s ctl in state %0d: got %h want %h", tag, exp_st, obs, e);
        end
    endtask

    // Walks one instruction's state list; rst_at >= 0 aborts it with reset there.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int rst_at);
        int seq[$];
        seq = {0, 1};
        case (op)
            6'b100011: seq = {0, 1, 2, 3, 4};
            6'b101011: seq = {0, 1, 2, 5};
            6'b000000: seq = {0, 1, 6, 7};
            6'b001000: seq = {0, 1, 9, 10};
            6'b000100: seq = {0, 1, 8};
            6'b000010: seq = {0, 1, 11};
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            reset  = (i == rst_at);
            opcode = op;
            funct  = fn;
            zero   = z;
            #3;
            check(tag, seq[i], reset, op, fn, z);
            @(posedge clk);
            #1;
            if (reset) break;
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        int         rst_at;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1; opcode = 6'b100011; funct = '0; zero = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #3;
            check("reset", 0, 1'b1, opcode, funct, zero);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run_instr("lw",        6'b100011, 6'b000000, 1'b0, -1);
        run_instr("sw",        6'b101011, 6'b000000, 1'b1, -1);
        run_instr("r_slt",     6'b000000, 6'b101010, 1'b0, -1);
        run_instr("r_and",     6'b000000, 6'b100100, 1'b0, -1);
        run_instr("r_unk",     6'b000000, 6'b111111, 1'b1, -1);
        run_instr("addi",      6'b001000, 6'b100101, 1'b0, -1);
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, -1);
        run_instr("beq_not",   6'b000100, 6'b000000, 1'b0, -1);
        run_instr("j",         6'b000010, 6'b000000, 1'b0, -1);
        run_instr("illegal",   6'b111111, 6'b000000, 1'b1, -1);
        run_instr("rst_memwr", 6'b101011, 6'b000000, 1'b0, 3);
        run_instr("rst_aluwb", 6'b000000, 6'b100010, 1'b1, 3);
        run_instr("after_rst", 6'b100011, 6'b000000, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            fn = ($urandom_range(0, 1) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len_of(op) - 1) : -1;
            run_instr("rand", op, fn, 1'($urandom), rst_at);
        end

        run_instr("final", 6'b000010, 6'b000000, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS core: a Moore state machine that sequences one shared ALU, one unified instruction/data memory and the register file over 3–5 cycles per instruction. It sits beside the datapath in `top`, sees only the latched instruction fields and the ALU `zero` flag, and drives every mux select and write enable. It replaces the single-cycle combinational decoder and shares the ALU between PC increment, address generation and execution.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: instr[31:26] from the instruction register.
- `funct` in 6: instr[5:0] from the instruction register.
- `zero` in 1: ALU zero flag, same cycle.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: write register select; 1 = rd, 0 = rt.
- `MemtoReg` out 1: write-back data select; 1 = data register, 0 = ALUOut.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = register A.
- `ALUSrcB` out 2: ALU B select; 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl` out 3: ALU operation code.
- `PCSrc` out 2: next-PC select; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn` out 1: PC load, equal to `PCWrite | (Branch & zero)`.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for bench visibility.

## Operation
- **Opcodes:**
  - R = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - addi = 001000
  - j = 000010
- **State encoding:**
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Codes 12–15 are unreachable and fall back to FETCH.
- **Transitions:**
  - FETCH → DECODE.
  - DECODE → MEMADR for lw/sw, EXECUTE for R, BRANCH for beq, ADDIEX for addi, JUMP for j.
  - DECODE → FETCH for any other opcode, with `illegal_op` = 1 during DECODE.
  - MEMADR → MEMRD for lw, MEMWR for sw. MEMRD → MEMWB → FETCH. MEMWR → FETCH.
  - EXECUTE → ALUWB → FETCH. ADDIEX → ADDIWB → FETCH. BRANCH → FETCH. JUMP → FETCH.
- **Per-state outputs** (anything not listed is 0; `ALUOp` defaults to 00):
  - FETCH: IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 00, IRWrite = 1, PCWrite = 1.
  - DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (precomputes the branch target).
  - MEMADR and ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
  - MEMRD: IorD = 1.
  - MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1.
  - MEMWR: IorD = 1, MemWrite = 1.
  - EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10.
  - ALUWB: RegDst = 1, MemtoReg = 0, RegWrite = 1.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSrc = 01, Branch = 1.
  - ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1.
  - JUMP: PCSrc = 10, PCWrite = 1.
- **ALU decode:**
  - ALUOp 00 → 010 (add); ALUOp 01 → 110 (subtract).
  - ALUOp 10 decodes `funct`: add 100000 → 010, sub 100010 → 110, and 100100 → 000, or 100101 → 001, slt 101010 → 111.
  - Unknown funct → 010, with no flag.
  - ALUOp 11 never occurs and maps to 010.

## Timing
- State register updates on the rising edge; all outputs are combinational from the registered state (Moore). The only Mealy terms are `PCEn` (from `zero`) and the DECODE `illegal_op`.
- Inputs are sampled:
  - `opcode` in DECODE and MEMADR;
  - `funct` in EXECUTE;
  - `zero` in BRANCH.
- The instruction register holds these inputs stable from DECODE onward.
- Cycles per instruction: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- **Reset:** while `reset` = 1, next state is FETCH and `IRWrite`, `PCEn`, `RegWrite`, `MemWrite`, `illegal_op` are forced to 0. Other outputs take their FETCH values. The first fetch occurs on the first edge after `reset` falls.
- **Reset mid-instruction** (e.g. in MEMWR or ALUWB): all write enables drop in the same cycle and no partial write completes.
- **BRANCH with `zero` = 0:** `PCEn` stays 0; the PC already holds PC+4 from FETCH.

## Structure
- Package `mips_mc_pkg` holds:
  - opcode and funct constants;
  - the state enum (4-bit);
  - the ALUOp encoding (2-bit);
  - the ALUControl codes (3-bit).
- One sub-module, `alu_decoder`: purely combinational, ALUOp + funct → ALUControl. The FSM lives in `multicycle_control`.

## Test plan
- **lw 100011:** reset for 1 cycle, then states 0→1→2→3→4→0. `IRWrite` = 1 only in state 0; `RegWrite` = 1 with `MemtoReg` = 1 only in state 4.
- **sw 101011:** states 0→1→2→5→0. `MemWrite` = 1 and `IorD` = 1 only in state 5; `RegWrite` is never 1.
- **R-type, funct 101010 (slt):** `ALUControl` = 111 in state 6. State 7 gives `RegDst` = 1, `RegWrite` = 1. Repeat for funct 100100 → 000 and funct 111111 → 010.
- **beq 000100:** with `zero` = 1 in BRANCH, `PCEn` = 1 and `PCSrc` = 01. With `zero` = 0, `PCEn` = 0. Both return to FETCH after 3 cycles.
- **j then illegal opcode 111111:** for j, state 11 gives `PCSrc` = 10, `PCEn` = 1. For 111111, `illegal_op` pulses 1 in DECODE, next state is 0, and no write enable asserts.
- **Reset asserted in state 5 (MEMWR):** `MemWrite` = 0 in that cycle and state = 0 on the next edge.
